// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if #(parameter int XLEN = 32);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [XLEN-1:0] rdata;
    modport master (output req, addr, input ready, rdata);
    modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage; holds PC, fetches over a req/ready bus, presents one instruction at a time.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    input  logic              PCsrc,
    input  logic [XLEN-1:0]   PCTarget,
    input  logic              stall,
    output logic [XLEN-1:0]   instr,
    output logic              instr_valid,
    output logic [XLEN-1:0]   PC,
    output logic [XLEN-1:0]   PCPlus4,
    output logic [XLEN-1:0]   retire_count,
    output logic              misalign_err
);
    typedef enum logic [1:0] {BOOT, FETCH, VALID, HALT} state_t;
    localparam logic [XLEN-1:0] ONE  = 1;
    localparam logic [XLEN-1:0] FOUR = 4;
    state_t state;
    assign imem.addr = PC;
    assign PCPlus4   = PC + FOUR;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            PC           <= RESET_PC;
            instr        <= '0;
            instr_valid  <= 1'b0;
            imem.req     <= 1'b0;
            retire_count <= '0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem.req <= 1'b1;
                end
                FETCH: if (imem.ready) begin
                    instr       <= imem.rdata;
                    instr_valid <= 1'b1;
                    imem.req    <= 1'b0;
                    state       <= VALID;
                end
                VALID: if (!stall) begin
                    retire_count <= retire_count + ONE;
                    instr_valid  <= 1'b0;
                    // A misaligned redirect keeps the PC of the offending instruction.
                    if (PCsrc && PCTarget[1:0] != 2'b00) begin
                        misalign_err <= 1'b1;
                        state        <= HALT;
                    end else begin
                        PC       <= PCsrc ? PCTarget : PCPlus4;
                        imem.req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an event-level reference model.
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n, PCsrc, stall, rst1_n, src1, stall1;
    logic [31:0] PCTarget, tgt1;
    logic [31:0] instr0, pc0, pcp0, cnt0, instr1, pc1, pcp1, cnt1;
    logic        v0, e0, v1, e1;
    fetch_unit_if bus0 ();
    fetch_unit_if bus1 ();
    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .imem(bus0), .PCsrc(PCsrc), .PCTarget(PCTarget), .stall(stall),
        .instr(instr0), .instr_valid(v0), .PC(pc0), .PCPlus4(pcp0), .retire_count(cnt0), .misalign_err(e0));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst1_n), .imem(bus1), .PCsrc(src1), .PCTarget(tgt1), .stall(stall1),
        .instr(instr1), .instr_valid(v1), .PC(pc1), .PCPlus4(pcp1), .retire_count(cnt1), .misalign_err(e1));

    int checks = 0, errors = 0;
    // Reference model for dut0: tracks booting, whether an instruction is held, halted, and the architectural counters.
    logic        m_boot, m_hold, m_halt, m_err;
    logic [31:0] m_pc, m_cnt, m_instr;

    task automatic model_reset();
        m_boot = 1; m_hold = 0; m_halt = 0; m_err = 0; m_pc = 32'h0; m_cnt = 0; m_instr = 0;
    endtask

    task automatic cyc(input logic rdy, input logic stl, input logic src, input logic [31:0] tgt);
        logic [31:0] d;
        d = $urandom;
        bus0.ready = rdy; bus0.rdata = d; stall = stl; PCsrc = src; PCTarget = tgt;
        if (m_boot) m_boot = 0;
        else if (m_halt) ;
        else if (!m_hold) begin
            if (rdy) begin m_hold = 1; m_instr = d; end
        end else if (!stl) begin
            m_cnt = m_cnt + 1; m_hold = 0;
            if (src && tgt[1:0] != 0) begin m_err = 1; m_halt = 1; end
            else m_pc = src ? tgt : m_pc + 4;
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic reset0();
        rst_n = 0; model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; model_reset();
        #1;
        checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc0, 32'h0); end
        checks++; if (bus0.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus0.req); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", v0); end
        checks++; if (instr0 !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr0); end
        checks++; if (cnt0 !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp 0", cnt0); end
        checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", e0); end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_sequential();
        reset0();
        checks++; if (bus0.req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", bus0.req); end
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus0.req !== 1'b1 || bus0.addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_fetch req %b addr %h exp 1 %h", bus0.req, bus0.addr, 32'(4 * k)); end
            cyc(1, 0, 0, 0);
            checks++; if (v0 !== 1'b1 || instr0 !== m_instr || cnt0 !== 32'(k)) begin errors++; $display("FAIL seq_valid v %b instr %h cnt %0d exp 1 %h %0d", v0, instr0, cnt0, m_instr, k); end
            cyc(1, 0, 0, 0);
        end
        checks++; if (cnt0 !== 32'd3 || bus0.addr !== 32'hC) begin errors++; $display("FAIL seq_end cnt %0d addr %h exp 3 c", cnt0, bus0.addr); end
    endtask

    task automatic test_wait();
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus0.req !== 1'b1 || bus0.addr !== 32'hC || v0 !== 1'b0) begin errors++; $display("FAIL wait req %b addr %h v %b exp 1 c 0", bus0.req, bus0.addr, v0); end
            cyc(0, 0, 0, 0);
        end
        cyc(1, 0, 0, 0);
        checks++; if (v0 !== 1'b1 || instr0 !== m_instr || pc0 !== 32'hC) begin errors++; $display("FAIL wait_capture v %b instr %h pc %h exp 1 %h c", v0, instr0, pc0, m_instr); end
    endtask

    task automatic test_redirect();
        cyc(0, 1, 1, 32'h80);
        checks++; if (v0 !== 1'b1 || pc0 !== 32'hC || cnt0 !== 32'd3) begin errors++; $display("FAIL stalled_pcsrc v %b pc %h cnt %0d exp 1 c 3", v0, pc0, cnt0); end
        cyc(0, 0, 1, 32'h40);
        checks++; if (bus0.req !== 1'b1 || bus0.addr !== 32'h40 || cnt0 !== 32'd4) begin errors++; $display("FAIL redirect req %b addr %h cnt %0d exp 1 40 4", bus0.req, bus0.addr, cnt0); end
        cyc(1, 0, 0, 0);
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = m_instr;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0);
            checks++; if (instr0 !== held || pc0 !== 32'h40 || cnt0 !== 32'd4 || bus0.req !== 1'b0 || v0 !== 1'b1) begin errors++; $display("FAIL stall instr %h pc %h cnt %0d req %b v %b exp %h 40 4 0 1", instr0, pc0, cnt0, bus0.req, v0, held); end
        end
        cyc(0, 0, 0, 0);
        checks++; if (cnt0 !== 32'd5 || bus0.addr !== 32'h44 || bus0.req !== 1'b1) begin errors++; $display("FAIL stall_release cnt %0d addr %h req %b exp 5 44 1", cnt0, bus0.addr, bus0.req); end
        cyc(1, 0, 0, 0);
    endtask

    task automatic test_misalign();
        cyc(0, 0, 1, 32'h42);
        checks++; if (e0 !== 1'b1 || bus0.req !== 1'b0 || v0 !== 1'b0 || pc0 !== 32'h44 || cnt0 !== 32'd6) begin errors++; $display("FAIL misalign err %b req %b v %b pc %h cnt %0d exp 1 0 0 44 6", e0, bus0.req, v0, pc0, cnt0); end
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 1, 32'h40);
            checks++; if (bus0.req !== 1'b0 || v0 !== 1'b0 || e0 !== 1'b1 || cnt0 !== 32'd6) begin errors++; $display("FAIL halt req %b v %b err %b cnt %0d exp 0 0 1 6", bus0.req, v0, e0, cnt0); end
        end
        reset0();
        checks++; if (e0 !== 1'b0 || cnt0 !== 32'h0 || bus0.req !== 1'b0) begin errors++; $display("FAIL halt_reset err %b cnt %0d req %b exp 0 0 0", e0, cnt0, bus0.req); end
        cyc(1, 0, 0, 0);
        checks++; if (bus0.req !== 1'b1 || bus0.addr !== 32'h0) begin errors++; $display("FAIL restart req %b addr %h exp 1 0", bus0.req, bus0.addr); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            reset0();
            for (int n = 0; n < 150; n++) begin
                logic [31:0] t;
                checks++; if (bus0.req !== (!m_boot && !m_hold && !m_halt)) begin errors++; $display("FAIL rnd_req got %b cyc %0d", bus0.req, n); end
                checks++; if (bus0.addr !== m_pc || pc0 !== m_pc || pcp0 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc addr %h pc %h pcp4 %h exp %h", bus0.addr, pc0, pcp0, m_pc); end
                checks++; if (v0 !== m_hold || (m_hold && instr0 !== m_instr)) begin errors++; $display("FAIL rnd_instr v %b instr %h exp %b %h", v0, instr0, m_hold, m_instr); end
                checks++; if (cnt0 !== m_cnt || e0 !== m_err) begin errors++; $display("FAIL rnd_count cnt %0d err %b exp %0d %b", cnt0, e0, m_cnt, m_err); end
                t = $urandom;
                if ($urandom_range(59) != 0) t[1:0] = 2'b00;
                cyc(1'($urandom_range(1)), $urandom_range(9) < 4, $urandom_range(3) == 0, t);
            end
        end
    endtask

    task automatic test_wrap();
        rst1_n = 0; #1;
        @(negedge clk); rst1_n = 1;
        checks++; if (bus1.req !== 1'b0) begin errors++; $display("FAIL wrap_boot req %b exp 0", bus1.req); end
        @(negedge clk);
        checks++; if (bus1.req !== 1'b1 || bus1.addr !== 32'hFFFF_FFFC || pcp1 !== 32'h0) begin errors++; $display("FAIL wrap_fetch req %b addr %h pcp4 %h exp 1 fffffffc 0", bus1.req, bus1.addr, pcp1); end
        bus1.ready = 1; bus1.rdata = 32'h0000_0013;
        @(negedge clk);
        checks++; if (v1 !== 1'b1 || instr1 !== 32'h13) begin errors++; $display("FAIL wrap_valid v %b instr %h exp 1 13", v1, instr1); end
        bus1.ready = 0;
        @(negedge clk);
        checks++; if (bus1.req !== 1'b1 || bus1.addr !== 32'h0 || cnt1 !== 32'd1) begin errors++; $display("FAIL wrap_next req %b addr %h cnt %0d exp 1 0 1", bus1.req, bus1.addr, cnt1); end
        bus1.ready = 1; bus1.rdata = 32'hDEAD_BEEF;
        #1 rst1_n = 0;
        #1;
        checks++; if (bus1.req !== 1'b0 || pc1 !== 32'hFFFF_FFFC || v1 !== 1'b0 || cnt1 !== 32'h0 || instr1 !== 32'h0) begin errors++; $display("FAIL async_reset req %b pc %h v %b cnt %0d instr %h exp 0 fffffffc 0 0 0", bus1.req, pc1, v1, cnt1, instr1); end
        @(negedge clk); rst1_n = 1;
        checks++; if (bus1.req !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL late_ready req %b v %b exp 0 0", bus1.req, v1); end
        @(negedge clk);
        checks++; if (bus1.req !== 1'b1 || v1 !== 1'b0 || bus1.addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL refetch req %b v %b addr %h exp 1 0 fffffffc", bus1.req, v1, bus1.addr); end
        @(negedge clk);
        checks++; if (v1 !== 1'b1 || instr1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL refetch_capture v %b instr %h exp 1 deadbeef", v1, instr1); end
    endtask

    initial begin
        rst1_n = 0; src1 = 0; tgt1 = 0; stall1 = 0; bus1.ready = 0; bus1.rdata = 0;
        PCsrc = 0; PCTarget = 0; stall = 0; bus0.ready = 0; bus0.rdata = 0;
        test_reset();
        test_sequential();
        test_wait();
        test_redirect();
        test_stall();
        test_misalign();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
